button_debouncer: RTL and testbench

Debounces a raw push-button input on the 12 MHz `clk` domain. It produces a clean level plus single-cycle rise/fall pulses. The block sits directly upstream of the go/rst inputs of the Moore state-machine stage, which receives `btn_level` as its `go` level. Input handling is a two-flop synchronizer, then a counter-qualified 4-state FSM.

---
 rtl/button_debouncer_pkg.sv | 17 +
 rtl/button_debouncer_sync_2ff.sv | 21 ++
 rtl/button_debouncer.sv | 98 +++++++++
 tb/tb_button_debouncer.sv | 96 +++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared state encodings and default 12 MHz timing constants for the
// button debouncer and the neighbouring state-machine stage.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int unsigned CLK_HZ             = 12_000_000;
    localparam int unsigned DEBOUNCE_MS        = 10;
    localparam int unsigned DEBOUNCE_CNT_MAX   = (CLK_HZ / 1000) * DEBOUNCE_MS - 1;
    localparam int unsigned DEBOUNCE_CNT_WIDTH = 18;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for raw asynchronous board inputs; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer plus counter-qualified 4-state FSM,
// producing a registered level and one-cycle rise/fall pulses.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEBOUNCE_CNT_WIDTH,
    parameter int unsigned CNT_MAX   = DEBOUNCE_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX);

    logic                 btn_s;
    db_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_d, rise_d, fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_level <= level_d;
            btn_rise  <= rise_d;
            btn_fall  <= fall_d;
        end
    end

    // Counter holds at CNT_LAST on acceptance, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = btn_level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (btn_s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!btn_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!btn_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (btn_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with CNT_MAX=3, CNT_WIDTH=4;
// outputs are compared as {btn_level, btn_rise, btn_fall}.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, btn_rise, btn_fall;

    int unsigned passed = 0;
    int unsigned total  = 0;

    button_debouncer #(
        .CNT_WIDTH (4),
        .CNT_MAX   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b (level,rise,fall) at %0t", tag, got, exp, $time);
    endtask

    // Drive btn_in for one cycle, then sample 1 time unit after the edge.
    task automatic step(input string tag, input logic b, input logic [2:0] exp);
        btn_in = b;
        @(posedge clk);
        #1;
        check(tag, {btn_level, btn_rise, btn_fall}, exp);
    endtask

    task automatic press(input string tag);
        for (int k = 1; k <= 10; k++)
            step(tag, 1'b1, (k < 7) ? 3'b000 : (k == 7) ? 3'b110 : 3'b100);
    endtask

    task automatic release_btn(input string tag);
        for (int k = 1; k <= 10; k++)
            step(tag, 1'b0, (k < 7) ? 3'b100 : (k == 7) ? 3'b001 : 3'b000);
    endtask

    initial begin
        logic [9:0] glitches;
        glitches = 10'b0011101101;

        // Reset holds everything at 0 even with the button pressed.
        for (int k = 0; k < 3; k++) step("reset_hold", 1'b1, 3'b000);
        btn_in = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) step("post_reset", 1'b0, 3'b000);

        press("clean_press");
        release_btn("release");

        // High 4, low 2, high 3, then low: CNT_MAX+1 high is still a bounce.
        for (int k = 1; k <= 20; k++)
            step("bounce", (k <= 4) || (k >= 7 && k <= 9), 3'b000);

        for (int k = 0; k < 10; k++) step("bouncy_glitch", glitches[k], 3'b000);
        press("bouncy_steady");
        release_btn("bouncy_release");

        // Reset mid-count: cnt reaches 2 after edge 5.
        for (int k = 1; k <= 5; k++) step("pre_rst_count", 1'b1, 3'b000);
        #2 rst = 1'b1;
        #1 check("rst_async", {btn_level, btn_rise, btn_fall}, 3'b000);
        for (int k = 0; k < 3; k++) step("rst_mid", 1'b1, 3'b000);
        #3 rst = 1'b0;
        press("rst_rerun");
        release_btn("rst_release");

        // Two-cycle glitch must never reach btn_level.
        step("glitch2", 1'b1, 3'b000);
        step("glitch2", 1'b1, 3'b000);
        for (int k = 0; k < 10; k++) step("glitch2", 1'b0, 3'b000);

        // CNT_MAX+2 cycles high is the shortest accepted press.
        for (int k = 1; k <= 14; k++)
            step("min_press", k <= 5,
                 (k < 7) ? 3'b000 : (k == 7) ? 3'b110 : (k <= 11) ? 3'b100 :
                 (k == 12) ? 3'b001 : 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
